// File: rtl/and_arb_pkg.sv
// ---------------------------------------------------------------------------
// and_arb_pkg
// Shared types and helpers for the round-robin AND-register arbiter.
//   state_t  : output register occupancy (EMPTY / FULL)
//   STAT_W   : width of each per-requester grant counter
//   MAX_REQ  : largest supported requester count
//   pick_t   : result of a round-robin scan (found flag + winner index)
//   rr_pick  : round-robin scan starting at ptr over the first n valid bits
// ---------------------------------------------------------------------------
package and_arb_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    localparam int STAT_W  = 16;
    localparam int MAX_REQ = 8;

    typedef struct packed {
        logic       found;
        logic [2:0] idx;
    } pick_t;

    // Scans ptr, ptr+1, ... (mod n) and returns the first set valid bit.
    // The loop runs to the fixed MAX_REQ bound so it unrolls to a constant
    // structure; offsets at or beyond n are ignored.
    function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] valid,
                                      input logic [2:0]         ptr,
                                      input int                 n);
        pick_t      r;
        int         j;
        logic [2:0] jj;
        r.found = 1'b0;
        r.idx   = '0;
        for (int k = 0; k < MAX_REQ; k++) begin
            if (k < n) begin
                j = int'(ptr) + k;
                if (j >= n) j = j - n;
                jj = 3'(j);
                if (!r.found && valid[jj]) begin
                    r.found = 1'b1;
                    r.idx   = jj;
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/and_reg_stage.sv
// ---------------------------------------------------------------------------
// and_reg_stage
// Registered bitwise AND with load enable.
//   clk : rising-edge clock
//   rst : asynchronous active-low reset, clears q
//   a,b : operands
//   en  : load a & b into q at the next rising edge
//   q   : registered result, holds when en is low
// ---------------------------------------------------------------------------
module and_reg_stage #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             en,
    output logic [WIDTH-1:0] q
);

    // NOTE: sequential state is written with non-blocking assignments so every
    // flop samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= '0;
        end else if (en) begin
            q <= a & b;
        end
    end

endmodule

// File: rtl/and_reg_arbiter.sv
// ---------------------------------------------------------------------------
// and_reg_arbiter
// Round-robin arbiter sharing one registered AND stage between N_REQ
// requesters. One operand pair is granted per cycle; the result is held in a
// single-entry output register tagged with the requester index.
//   clk        : rising-edge clock
//   rst        : asynchronous active-low reset
//   req_valid  : per-requester operand valid
//   req_a/b    : operands, requester i at [i*WIDTH +: WIDTH]
//   req_ready  : per-requester accept, one-hot or zero
//   rsp_valid  : output register holds a result
//   rsp_data   : registered a & b
//   rsp_id     : requester index that produced rsp_data
//   rsp_ready  : downstream accepts the result
// Optional (macro AND_ARB_STATS_EN):
//   grant_cnt  : per-requester saturating 16-bit transfer counters
//   stats_clr  : synchronous clear of all counters (wins over a transfer)
// ---------------------------------------------------------------------------
module and_reg_arbiter
    import and_arb_pkg::*;
#(
    parameter  int N_REQ = 4,
    parameter  int WIDTH = 8,
    localparam int ID_W  = $clog2(N_REQ)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*WIDTH-1:0]  req_a,
    input  logic [N_REQ*WIDTH-1:0]  req_b,
    output logic [N_REQ-1:0]        req_ready,
    output logic                    rsp_valid,
    output logic [WIDTH-1:0]        rsp_data,
    output logic [ID_W-1:0]         rsp_id,
`ifdef AND_ARB_STATS_EN
    output logic [N_REQ*STAT_W-1:0] grant_cnt,
    input  logic                    stats_clr,
`endif
    input  logic                    rsp_ready
);

    state_t           state;
    logic [ID_W-1:0]  rr_ptr;
    logic [ID_W-1:0]  winner;
    pick_t            pick;
    logic             can_accept;
    logic             xfer;
    logic [WIDTH-1:0] a_sel;
    logic [WIDTH-1:0] b_sel;

    // NOTE: every output of this block gets a default before any condition,
    // so no path leaves a value unassigned and no latch is inferred.
    always_comb begin
        pick       = rr_pick(MAX_REQ'(req_valid), 3'(rr_ptr), N_REQ);
        winner     = ID_W'(pick.idx);
        // A full register can still take a new result if it drains this cycle.
        can_accept = (state == EMPTY) || rsp_ready;
        xfer       = pick.found && can_accept && rst;
        req_ready  = '0;
        if (xfer) req_ready[winner] = 1'b1;
        a_sel      = req_a[winner*WIDTH +: WIDTH];
        b_sel      = req_b[winner*WIDTH +: WIDTH];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= EMPTY;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rr_ptr    <= '0;
        end else if (xfer) begin
            // Covers both the EMPTY fill and the FULL back-to-back replace.
            state     <= FULL;
            rsp_valid <= 1'b1;
            rsp_id    <= winner;
            rr_ptr    <= (winner == ID_W'(N_REQ - 1)) ? '0 : winner + 1'b1;
        end else if (state == FULL && rsp_ready) begin
            state     <= EMPTY;
            rsp_valid <= 1'b0;
        end
    end

    and_reg_stage #(
        .WIDTH (WIDTH)
    ) u_stage (
        .clk (clk),
        .rst (rst),
        .a   (a_sel),
        .b   (b_sel),
        .en  (xfer),
        .q   (rsp_data)
    );

`ifdef AND_ARB_STATS_EN
    logic [STAT_W-1:0] cnt [N_REQ];

    // NOTE: the counter array is small and architecturally visible, so it is
    // reset like ordinary flops rather than left uninitialised like a RAM.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N_REQ; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (stats_clr) begin
                    cnt[i] <= '0;
                end else if (xfer && int'(winner) == i && cnt[i] != '1) begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    for (genvar g = 0; g < N_REQ; g++) begin : g_cnt
        assign grant_cnt[g*STAT_W +: STAT_W] = cnt[g];
    end
`endif

endmodule

// File: doc/and_reg_arbiter.md
Name: and_reg_arbiter

Overview:
- Round-robin arbiter that shares one registered AND datapath (bitwise AND of two operands into a D flip-flop stage) between N_REQ requesters.
- Each requester offers an operand pair with valid/ready.
- The block grants one requester per cycle, computes a AND b into a single-entry output register, and presents the result tagged with the requester index on a valid/ready response port.
- Sits between requester logic and the shared register stage; owns all sequencing of that stage.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- WIDTH, 8, operand and result width in bits
- ID_W, $clog2(N_REQ), width of requester index (derived; not overridden)

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous active-low reset
- req_valid  input  N_REQ  per-requester operand valid
- req_a  input  N_REQ*WIDTH  operand A, requester i in bits [i*WIDTH +: WIDTH]
- req_b  input  N_REQ*WIDTH  operand B, same packing
- req_ready  output  N_REQ  per-requester accept; one-hot or zero
- rsp_valid  output  1  result register holds valid data
- rsp_data  output  WIDTH  registered a AND b
- rsp_id  output  ID_W  index of the requester that produced rsp_data
- rsp_ready  input  1  downstream accepts result

Behaviour:
- Reset (rst low, async): rsp_valid=0, rsp_data=0, rsp_id=0, rr_ptr=0, FSM=EMPTY. req_ready=0 while rst is low.
- FSM states:
  - EMPTY: output register holds no data.
  - FULL: output register holds data.
- can_accept = (state==EMPTY) || rsp_ready.
- Arbitration (combinational): scan indices rr_ptr, rr_ptr+1, ... mod N_REQ. The first with req_valid set is the winner. No winner if all valid bits are 0.
- req_ready[winner] = can_accept. All other req_ready bits = 0. req_ready may depend combinationally on req_valid and rsp_ready. Requesters must not make req_valid depend on req_ready.
- Transfer on requester i: req_valid[i] && req_ready[i].
- On a transfer at a clock edge:
  - rsp_data <= req_a[i] & req_b[i]
  - rsp_id <= i
  - rsp_valid <= 1
  - state <= FULL
  - rr_ptr <= (i+1) mod N_REQ
- Latency: exactly 1 cycle from accepting edge to rsp_valid high.
- FULL with rsp_ready=1 and no transfer: rsp_valid <= 0, state <= EMPTY. rsp_data and rsp_id hold their last value.
- FULL with rsp_ready=1 and a transfer in the same cycle: back-to-back. Result is replaced, rsp_valid stays 1, full throughput of one result per cycle.
- FULL with rsp_ready=0: all req_ready=0. rsp_data, rsp_id and rsp_valid held stable; rr_ptr unchanged.
- rr_ptr advances only on a transfer. Wrap from N_REQ-1 to 0.
- Fairness: with all N_REQ valid continuously and rsp_ready=1, grants rotate 0,1,...,N_REQ-1,0. Worst-case wait is N_REQ-1 grants.
- Requester-side stability: a requester holding req_valid keeps req_a/req_b stable until its transfer. The arbiter does not latch unaccepted operands.
- Reset mid-operation: any pending result is discarded. rsp_valid drops asynchronously; rr_ptr returns to 0.

Optional Feature:
- Macro: AND_ARB_STATS_EN.
- When defined:
  - Adds output port grant_cnt, width N_REQ*16: per-requester saturating 16-bit counters of transfers.
  - Adds input stats_clr (1 bit), which synchronously zeroes all counters. A transfer in the same cycle as stats_clr is not counted.
  - Counters reset to 0 on rst and saturate at 16'hFFFF.
- When undefined: neither port exists; no counter logic; all other behaviour identical.

Decomposition:
- Shared package and_arb_pkg:
  - state enum (EMPTY, FULL)
  - localparam STAT_W=16
  - function rr_pick(valid, ptr) returning winner index and found flag
- One sub-module: and_reg_stage. Holds the registered AND with enable, async active-low rst, and ports a, b, en, q. Instantiated once for rsp_data.
- Arbitration and FSM stay in the top.

Test Plan:
- Reset: drive rst=0 mid-stream with rsp_valid=1 -> rsp_valid, rsp_data, rsp_id read 0 immediately; after release the first grant goes to req 0 when all are valid.
- Single requester: req 2 valid, a=8'hF0, b=8'h3C, rsp_ready=1 -> req_ready=4'b0100; next cycle rsp_valid=1, rsp_data=8'h30, rsp_id=2.
- Round robin: all 4 valid continuously, rsp_ready=1 -> rsp_id sequence 0,1,2,3,0,1 on consecutive cycles, one result per cycle.
- Backpressure: rsp_ready=0 for 3 cycles while FULL with data 8'hAA -> req_ready=0 and rsp_data stays 8'hAA for 3 cycles; first rsp_ready=1 cycle accepts the next grant (back-to-back).
- Wrap/skip: rr_ptr=3, only req 1 valid -> req 1 granted, rr_ptr becomes 2; next req 0 and req 3 both valid -> req 3 wins.
- AND_ARB_STATS_EN: 5 grants to req 0, pulse stats_clr, then 2 grants -> grant_cnt for req 0 reads 5 before the clear and 2 after.
